// File: rtl/alu_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_div_pkg
// Brief    : Shared state encoding and default width for the sequential divider.
// Revision : 1.0  initial release
// ============================================================================
package alu_div_pkg;

    localparam int c_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : alu_div_pkg
`default_nettype wire

// File: rtl/alu_seq_div_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_div_if
// Brief    : Start/done request and result bundle of the sequential divider.
// Revision : 1.0  initial release
// ============================================================================
interface alu_seq_div_if
    import alu_div_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, quotient, remainder, div_by_zero, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, quotient, remainder, div_by_zero, zero
    );

endinterface : alu_seq_div_if
`default_nettype wire

// File: rtl/alu_div_step.sv
`default_nettype none
// ============================================================================
// Module   : alu_div_step
// Brief    : One combinational restoring-division step (shift, compare, subtract).
// Revision : 1.0  initial release
// ============================================================================
module alu_div_step
    import alu_div_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  wire logic [WIDTH-1:0] i_pr,
    input  wire logic             i_bit,
    input  wire logic [WIDTH-1:0] i_divisor,
    output logic      [WIDTH-1:0] o_pr_next,
    output logic                  o_q_bit
);

    logic [WIDTH:0] w_shift;
    logic           w_ge;

    // The shifted value needs WIDTH+1 bits for the compare; after a subtract
    // the result is below the divisor, so the low WIDTH bits are exact.
    assign w_shift   = {i_pr, i_bit};
    assign w_ge      = (w_shift >= {1'b0, i_divisor});
    assign o_q_bit   = w_ge;
    assign o_pr_next = w_ge ? (w_shift[WIDTH-1:0] - i_divisor) : w_shift[WIDTH-1:0];

endmodule : alu_div_step
`default_nettype wire

// File: rtl/alu_seq_div.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_div
// Brief    : Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Revision : 1.0  initial release
// ============================================================================
module alu_seq_div
    import alu_div_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    alu_seq_div_if.slave bus
);

    localparam int             c_CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;

    logic [WIDTH-1:0]  r_dividend;
    logic [WIDTH-1:0]  r_divisor;
    logic [WIDTH-1:0]  r_pr;
    logic [c_CW-1:0]   r_count;
    logic [WIDTH-1:0]  r_quotient;
    logic [WIDTH-1:0]  r_remainder;
    logic              r_dbz;
    logic              r_zero;

    logic              w_accept;
    logic              w_b_zero;
    logic              w_last;
    logic [WIDTH-1:0]  w_pr_nxt;
    logic              w_qbit;
    logic [WIDTH-1:0]  w_quot_fin;
    logic              w_busy;
    logic              w_done;

    assign w_accept   = bus.start && (r_state != ST_RUN);
    assign w_b_zero   = (bus.b == '0);
    assign w_last     = (r_count == c_LAST);
    // Quotient bits shift into the dividend register as its bits shift out.
    assign w_quot_fin = {r_dividend[WIDTH-2:0], w_qbit};

    alu_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_pr      (r_pr),
        .i_bit     (r_dividend[WIDTH-1]),
        .i_divisor (r_divisor),
        .o_pr_next (w_pr_nxt),
        .o_q_bit   (w_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_b_zero ? ST_DONE : ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_RUN:  w_busy = 1'b1;
            ST_DONE: w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_pr        <= '0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_accept) begin
            if (w_b_zero) begin
                r_quotient  <= '0;
                r_remainder <= '0;
                r_dbz       <= 1'b1;
                r_zero      <= 1'b1;
            end else begin
                r_dividend <= bus.a;
                r_divisor  <= bus.b;
                r_pr       <= '0;
                r_count    <= '0;
            end
        end else if (r_state == ST_RUN) begin
            r_dividend <= w_quot_fin;
            r_pr       <= w_pr_nxt;
            r_count    <= r_count + 1'b1;
            if (w_last) begin
                r_quotient  <= w_quot_fin;
                r_remainder <= w_pr_nxt;
                r_zero      <= (w_quot_fin == '0);
                r_dbz       <= 1'b0;
            end
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;
    assign bus.zero        = r_zero;

endmodule : alu_seq_div
`default_nettype wire

// File: tb/tb_alu_seq_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_div
// Brief    : Directed self-checking bench for the sequential divider.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq_div;

    localparam int c_W = 8;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   prev_q;
    int   prev_r;

    alu_seq_div_if #(.WIDTH(c_W)) bus ();

    alu_seq_div #(
        .WIDTH (c_W)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int a, input int b);
        bus.start = 1'b1;
        bus.a     = c_W'(a);
        bus.b     = c_W'(b);
        tick();
        bus.start = 1'b0;
    endtask

    // Runs until done (bounded), checking busy and output hold on the way,
    // then checks latency and the finished result.
    task automatic wait_done(input int elapsed, input int exp_lat,
                             input int exp_q, input int exp_r,
                             input int exp_dbz, input int exp_zero);
        int n;
        n = elapsed;
        while (bus.done !== 1'b1 && n < 40) begin
            chk("busy_in_run", bus.busy, 1);
            chk("hold_q", bus.quotient, prev_q);
            chk("hold_r", bus.remainder, prev_r);
            tick();
            n++;
        end
        chk("latency", n, exp_lat);
        chk("done", bus.done, 1);
        chk("busy_in_done", bus.busy, 0);
        chk("quotient", bus.quotient, exp_q);
        chk("remainder", bus.remainder, exp_r);
        chk("div_by_zero", bus.div_by_zero, exp_dbz);
        chk("zero", bus.zero, exp_zero);
        prev_q = exp_q;
        prev_r = exp_r;
    endtask

    task automatic run_pair(input int a, input int b);
        int q;
        int r;
        q = (b != 0) ? a / b : 0;
        r = (b != 0) ? a % b : 0;
        issue(a, b);
        wait_done(0, (b != 0) ? c_W : 0, q, r, (b == 0) ? 1 : 0, (q == 0) ? 1 : 0);
        if (b != 0) begin
            chk("invariant", bus.quotient * b + bus.remainder, a);
            chk("rem_lt_b", (bus.remainder < b) ? 1 : 0, 1);
        end
        tick();
        chk("done_pulse", bus.done, 0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        prev_q    = 0;
        prev_r    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Idle after reset with no request
        repeat (5) tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_q", bus.quotient, 0);
        chk("rst_r", bus.remainder, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        chk("rst_zero", bus.zero, 0);

        // 200 / 7 = 28 r 4
        issue(200, 7);
        wait_done(0, 8, 28, 4, 0, 0);
        tick();
        chk("done_one_cycle", bus.done, 0);
        chk("hold_after_done", bus.quotient, 28);

        // Divide by zero: done one cycle after accept, busy never set
        issue(5, 0);
        chk("dbz_no_busy", bus.busy, 0);
        wait_done(0, 0, 0, 0, 1, 1);
        tick();
        chk("dbz_done_pulse", bus.done, 0);

        // 3 / 10, then 255 / 1 issued in the done cycle
        issue(3, 10);
        wait_done(0, 8, 0, 3, 0, 1);
        issue(255, 1);
        chk("b2b_done_drop", bus.done, 0);
        chk("b2b_busy", bus.busy, 1);
        wait_done(0, 8, 255, 0, 0, 0);
        tick();

        // Request during RUN is ignored; operands may change freely
        issue(100, 9);
        tick();
        bus.start = 1'b1;
        bus.a     = 8'd9;
        bus.b     = 8'd3;
        tick();
        bus.start = 1'b0;
        bus.a     = 8'd77;
        bus.b     = 8'd0;
        chk("mid_busy", bus.busy, 1);
        tick();
        wait_done(3, 8, 11, 1, 0, 0);
        tick();

        // Reset in the middle of an operation
        issue(50, 6);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_q", bus.quotient, 0);
        chk("arst_r", bus.remainder, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        tick();
        rst_n  = 1'b1;
        prev_q = 0;
        prev_r = 0;
        for (int i = 0; i < 12; i++) begin
            chk("arst_no_done", bus.done, 0);
            tick();
        end

        // Corner pairs
        run_pair(77, 1);
        run_pair(123, 123);
        run_pair(0, 5);
        run_pair(254, 255);
        run_pair(255, 255);
        run_pair(255, 254);
        run_pair(1, 255);
        run_pair(0, 0);
        run_pair(128, 2);

        // Random pairs
        for (int i = 0; i < 300; i++) begin
            run_pair(int'($urandom_range(0, 255)), int'($urandom_range(1, 255)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_seq_div
`default_nettype wire
